// File: rtl/sr_jk_ff_bank.sv
// Bank of WIDTH synchronous flip-flops running as SR, JK, D or T, with forbidden-SR detection.
// Optional macro SR_SET_DOMINANT_EN makes S=R=1 in SR mode set the bit instead of holding it.
module sr_jk_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             illegal,
  output logic [WIDTH-1:0] illegal_mask,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] hit;

  always_comb begin
    next_q = q;
    case (mode)
`ifdef SR_SET_DOMINANT_EN
      2'b00: next_q = s | (q & ~r);
`else
      2'b00: next_q = (s & ~r) | (q & ~(s ^ r));
`endif
      2'b01: next_q = (s & ~q) | (~r & q);
      2'b10: next_q = s;
      2'b11: next_q = q ^ s;
      default: next_q = q;
    endcase
  end

  assign hit  = (mode == 2'b00) ? (s & r) : '0;
  assign qbar = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= '0;
      illegal      <= 1'b0;
      illegal_mask <= '0;
    end else if (en) begin
      q            <= next_q;
      illegal      <= |hit;
      illegal_mask <= hit;
    end else begin
      illegal      <= 1'b0;
      illegal_mask <= '0;
    end
  end

  // Counts each edge that registers illegal=1; clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      illegal_cnt <= '0;
    end else if (en && (|hit) && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sr_jk_ff_bank.sv
// Table-driven scoreboard bench for sr_jk_ff_bank: a default instance and a CNT_W=2 instance share stimulus.
module tb_sr_jk_ff_bank;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;
    logic [7:0] q;
    logic       ill;
    logic [7:0] mask;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       ill;
    logic [7:0] mask;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

`ifdef SR_SET_DOMINANT_EN
  localparam logic [7:0] Q_SAT = 8'h25;
  localparam logic [7:0] Q_MIX = 8'hF5;
  localparam logic [7:0] Q_TOG = 8'h0A;
`else
  localparam logic [7:0] Q_SAT = 8'h24;
  localparam logic [7:0] Q_MIX = 8'hE4;
  localparam logic [7:0] Q_TOG = 8'h1B;
`endif

  logic       clk = 1'b0;
  logic       rst, en, clr_cnt;
  logic [1:0] mode;
  logic [7:0] s, r;
  logic [7:0] q, qbar, illegal_mask, illegal_cnt;
  logic       illegal;
  logic [7:0] q2, qbar2, illegal_mask2;
  logic       illegal2;
  logic [1:0] illegal_cnt2;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  sr_jk_ff_bank #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(q), .qbar(qbar), .illegal(illegal), .illegal_mask(illegal_mask),
    .illegal_cnt(illegal_cnt)
  );

  sr_jk_ff_bank #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .clr_cnt(clr_cnt),
    .q(q2), .qbar(qbar2), .illegal(illegal2), .illegal_mask(illegal_mask2),
    .illegal_cnt(illegal_cnt2)
  );

  task automatic addVec(input logic vr, input logic ve, input logic [1:0] vm,
                        input logic [7:0] vs, input logic [7:0] vrr, input logic vc,
                        input logic [7:0] eq, input logic ei, input logic [7:0] em,
                        input logic [7:0] c8, input logic [1:0] c2);
    vec_t v;
    v.rst = vr; v.en = ve; v.mode = vm; v.s = vs; v.r = vrr; v.clr = vc;
    v.q = eq; v.ill = ei; v.mask = em; v.cnt8 = c8; v.cnt2 = c2;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input int idx, input string name,
                          input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL row%0d %s: got %h want %h", idx, name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst = v.rst; en = v.en; mode = v.mode; s = v.s; r = v.r; clr_cnt = v.clr;
    e.q = v.q; e.ill = v.ill; e.mask = v.mask; e.cnt8 = v.cnt8; e.cnt2 = v.cnt2;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL row%0d scoreboard: got empty want entry", idx);
    end else begin
      total--;
      e = sb.pop_front();
      checkVal(idx, "q", q, e.q);
      checkVal(idx, "qbar", qbar, ~e.q);
      checkVal(idx, "illegal", {7'd0, illegal}, {7'd0, e.ill});
      checkVal(idx, "mask", illegal_mask, e.mask);
      checkVal(idx, "cnt8", illegal_cnt, e.cnt8);
      checkVal(idx, "q_w2", q2, e.q);
      checkVal(idx, "illegal_w2", {7'd0, illegal2}, {7'd0, e.ill});
      checkVal(idx, "cnt2", {6'd0, illegal_cnt2}, {6'd0, e.cnt2});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; s = 8'hFF; r = 8'hFF; clr_cnt = 1'b0;

    // rst en mode s r clr | q ill mask cnt8 cnt2
    addVec(1,1,2'd0,8'hFF,8'hFF,0, 8'h00,0,8'h00,8'd0,2'd0);
    addVec(1,1,2'd0,8'hFF,8'hFF,0, 8'h00,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd0,8'h00,8'hFF,0, 8'h00,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd0,8'hFF,8'h00,0, 8'hFF,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd0,8'h00,8'h00,0, 8'hFF,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd0,8'hFF,8'hFF,0, 8'hFF,1,8'hFF,8'd1,2'd1);
    addVec(0,1,2'd0,8'h00,8'h00,0, 8'hFF,0,8'h00,8'd1,2'd1);
    // JK toggling from 0x0F, then D, T and disabled hold
    addVec(0,1,2'd2,8'h0F,8'h00,0, 8'h0F,0,8'h00,8'd1,2'd1);
    addVec(0,1,2'd1,8'hFF,8'hFF,0, 8'hF0,0,8'h00,8'd1,2'd1);
    addVec(0,1,2'd1,8'hFF,8'hFF,0, 8'h0F,0,8'h00,8'd1,2'd1);
    addVec(0,1,2'd1,8'hFF,8'hFF,0, 8'hF0,0,8'h00,8'd1,2'd1);
    addVec(0,1,2'd2,8'hA5,8'h5A,0, 8'hA5,0,8'h00,8'd1,2'd1);
    addVec(0,1,2'd3,8'h81,8'h00,0, 8'h24,0,8'h00,8'd1,2'd1);
    addVec(0,0,2'd0,8'hFF,8'hFF,0, 8'h24,0,8'h00,8'd1,2'd1);
    // Clear, then five illegal cycles to saturate the 2-bit counter
    addVec(0,1,2'd0,8'h00,8'h00,1, 8'h24,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd0,8'h01,8'h01,0, Q_SAT,1,8'h01,8'd1,2'd1);
    addVec(0,1,2'd0,8'h01,8'h01,0, Q_SAT,1,8'h01,8'd2,2'd2);
    addVec(0,1,2'd0,8'h01,8'h01,0, Q_SAT,1,8'h01,8'd3,2'd3);
    addVec(0,1,2'd0,8'h01,8'h01,0, Q_SAT,1,8'h01,8'd4,2'd3);
    addVec(0,1,2'd0,8'h01,8'h01,0, Q_SAT,1,8'h01,8'd5,2'd3);
    addVec(0,1,2'd0,8'h01,8'h01,1, Q_SAT,1,8'h01,8'd0,2'd0);
    addVec(0,0,2'd0,8'h01,8'h01,0, Q_SAT,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd0,8'hF0,8'h30,0, Q_MIX,1,8'h30,8'd1,2'd1);
    // Reset in the middle of JK toggling
    addVec(0,1,2'd1,8'hFF,8'hFF,0, Q_TOG,0,8'h00,8'd1,2'd1);
    addVec(1,1,2'd1,8'hFF,8'hFF,0, 8'h00,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd1,8'hFF,8'hFF,0, 8'hFF,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd1,8'hFF,8'hFF,0, 8'h00,0,8'h00,8'd0,2'd0);
    addVec(0,1,2'd1,8'h0F,8'hF0,0, 8'h0F,0,8'h00,8'd0,2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_jk_ff_bank.md
Name: sr_jk_ff_bank

Overview:
- Parametrised, clocked bank of WIDTH independent storage bits.
- Each bit behaves as an SR, JK, D or T flip-flop, selected by a shared mode input.
- Next-generation replacement for the single-bit level-sensitive SR latch. It adds:
  - synchronous operation and an enable;
  - defined handling of the forbidden SR input S=R=1;
  - a saturating counter of forbidden-input events for debug.

Parameters:
- WIDTH, 8, number of flip-flop channels (>=1).
- CNT_W, 8, width of the illegal-event counter (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  update enable; 0 = all channels hold, no illegal detection.
- mode  input  2  00 SR, 01 JK, 10 D, 11 T (sampled each cycle, applies to all channels).
- s  input  WIDTH  S / J / D / T input per channel.
- r  input  WIDTH  R / K input per channel; ignored in D and T modes.
- clr_cnt  input  1  synchronous clear of illegal_cnt.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  always exactly ~q (combinational from q).
- illegal  output  1  registered one-cycle pulse: forbidden SR input seen on the previous edge.
- illegal_mask  output  WIDTH  registered; which channels had S=R=1 in SR mode on the previous edge.
- illegal_cnt  output  CNT_W  saturating count of edges with illegal=1.

Behaviour:
- Reset (rst=1 at rising edge) has priority over everything:
  - q=0, qbar=all 1s;
  - illegal=0, illegal_mask=0, illegal_cnt=0.
- All state updates occur on the rising clk edge only. Latency is one cycle from inputs to q.
- en=0:
  - q holds;
  - illegal and illegal_mask are cleared to 0 on that edge;
  - illegal_cnt holds, unless clr_cnt=1.
- en=1, per channel i, next q[i] by mode:
  - SR (00): s=1,r=0 -> 1; s=0,r=1 -> 0; s=0,r=0 -> hold; s=1,r=1 -> hold (forbidden, flagged).
  - JK (01): 00 hold, 10 set, 01 reset, 11 toggle. Not flagged.
  - D (10): q[i] <= s[i]; r ignored.
  - T (11): q[i] <= q[i] ^ s[i]; r ignored.
- Illegal detection, registered on each edge with en=1 and rst=0:
  - illegal_mask <= (mode==00) ? (s & r) : 0.
  - illegal <= |(s & r) when mode==00, else 0.
- Counter:
  - Increments by 1 on each edge where the newly registered illegal is 1, i.e. it counts in the same edge the event is sampled.
  - Saturates at 2^CNT_W-1; no wrap.
  - Multiple channels illegal in one cycle count as one event.
- clr_cnt=1 sets illegal_cnt to 0 on that edge. This overrides a simultaneous increment. It does not affect illegal or illegal_mask.
- Mode change between cycles takes effect immediately on the next edge; there is no state conversion.
- Reset asserted mid-sequence discards the pending inputs of that cycle.
- Inputs X/Z are not handled; the bench must drive known values.

Optional Feature:
- Macro SR_SET_DOMINANT_EN.
- Defined: in SR mode, s=r=1 sets q[i] to 1 instead of holding. illegal, illegal_mask and counter behaviour are unchanged (still flagged).
- Undefined: s=r=1 in SR mode holds q[i].
- Has no effect in JK, D or T modes.

Test Plan:
- Reset: drive rst=1 for 2 cycles with s=r=all 1s, en=1, mode=00 -> q=0x00, qbar=0xFF, illegal=0, illegal_cnt=0.
- SR sequence (WIDTH=8, mode=00, en=1) applied each cycle: s/r=01,10,00,11,00 on all channels -> q=00,FF,FF, then FF hold (set 0xFF with SR_SET_DOMINANT_EN), then FF.
  - illegal=1 and illegal_mask=0xFF only in the cycle after 11.
  - illegal_cnt=1.
- JK toggle: q=0x0F, mode=01, s=r=0xFF for 3 cycles -> q=F0, 0F, F0; illegal stays 0.
- D/T modes:
  - mode=10, s=0xA5, r=0x5A -> q=0xA5.
  - Then mode=11, s=0x81 -> q=0x24.
  - Then en=0 with s=0xFF -> q stays 0x24.
- Counter saturation and clear: CNT_W=2, 5 consecutive SR cycles with s=r=0x01 -> illegal_cnt=1,2,3,3,3.
  - Then clr_cnt=1 in the same cycle as another illegal input -> illegal_cnt=0, illegal=1.
- Reset mid-operation: mode=01 toggling, assert rst for 1 cycle -> q=0 at that edge, illegal_cnt=0, toggling resumes from 0 after release.
